// File: rtl/sync_down_counter_pkg.sv
// Shared counter definitions: FSM state encodings and the default counter width.
package sync_down_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

endpackage

// File: rtl/sync_down_counter_dff.sv
// Single-bit D flip-flop with clock enable and asynchronous active-low reset.
module d_flip_flop_en (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sync_down_counter.sv
// Loadable down counter with one-shot / auto-reload expiry, terminal count and done pulse.
// Storage for count, reload value and done is built from per-bit enabled flip-flops.
module sync_down_counter
    import sync_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             done,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] reload;
    logic             q_en;
    logic             done_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Load overrides everything, including an expiry on the same edge.
    always_comb begin
        state_nxt = IDLE;
        q_nxt     = q;
        q_en      = 1'b0;
        done_nxt  = 1'b0;
        if (load) begin
            q_en      = 1'b1;
            q_nxt     = load_val;
            state_nxt = (load_val != '0) ? COUNT : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = IDLE;
                end
                COUNT: begin
                    state_nxt = COUNT;
                    if (en) begin
                        q_en = 1'b1;
                        if (q > ONE) begin
                            q_nxt = q - ONE;
                        end else if (q == ONE) begin
                            done_nxt = 1'b1;
                            if (auto_reload) begin
                                q_nxt = reload;
                            end else begin
                                q_nxt     = '0;
                                state_nxt = IDLE;
                            end
                        end else begin
                            // Zero count while COUNT is unreachable; park without decrementing.
                            q_nxt     = q;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_flip_flop_en u_count (
            .clk (clk),
            .rst (rst),
            .en  (q_en),
            .d   (q_nxt[i]),
            .q   (q[i])
        );

        d_flip_flop_en u_reload (
            .clk (clk),
            .rst (rst),
            .en  (load),
            .d   (load_val[i]),
            .q   (reload[i])
        );
    end

    d_flip_flop_en u_done (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (done_nxt),
        .q   (done)
    );

    assign busy = (state == COUNT);
    assign tc   = (q == '0);

endmodule

// File: tb/tb_sync_down_counter.sv
// Scoreboarded bench for sync_down_counter (WIDTH = 4): expected {q, done, busy, tc} queued per driven cycle.
module tb_sync_down_counter;

    localparam int WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             done;
        logic             busy;
        logic             tc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             done;
    logic             busy;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    sync_down_counter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .auto_reload (auto_reload),
        .q           (q),
        .tc          (tc),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int qv, input bit d, input bit b);
        exp_t e;
        e.q    = WIDTH'(qv);
        e.done = d;
        e.busy = b;
        e.tc   = (qv == 0);
        return e;
    endfunction

    task automatic test_reset();
        exp_t e;
        rst = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;
        #2;
        exp_q.push_back(mk(0, 0, 0));
        e = exp_q.pop_front();
        checks++;
        if ({q, done, busy, tc} !== e) $display("FAIL reset_initial: got q=%0d done=%b busy=%b tc=%b, expected q=%0d done=%b busy=%b tc=%b", q, done, busy, tc, e.q, e.done, e.busy, e.tc);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk(0, 0, 0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({q, done, busy, tc} !== e) $display("FAIL reset_idle cyc%0d: got q=%0d done=%b busy=%b tc=%b, expected q=%0d done=%b busy=%b tc=%b", i, q, done, busy, tc, e.q, e.done, e.busy, e.tc);
            else passed++;
        end
    endtask

    task automatic test_one_shot();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            load        = (i == 0);
            load_val    = 4'd5;
            en          = 1'b1;
            auto_reload = (i == 1 || i == 2);
            exp_q.push_back(mk((i < 6) ? 5 - i : 0, i == 5, i < 5));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({q, done, busy, tc} !== e) $display("FAIL one_shot cyc%0d: got q=%0d done=%b busy=%b tc=%b, expected q=%0d done=%b busy=%b tc=%b", i, q, done, busy, tc, e.q, e.done, e.busy, e.tc);
            else passed++;
        end
    endtask

    task automatic test_auto_reload();
        exp_t e;
        int   pulses = 0;
        for (int i = 0; i < 13; i++) begin
            load        = (i == 0);
            load_val    = 4'd3;
            en          = 1'b1;
            auto_reload = 1'b1;
            exp_q.push_back(mk((i % 3 == 0) ? 3 : 3 - (i % 3), (i > 0) && (i % 3 == 0), 1));
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
            e = exp_q.pop_front();
            checks++;
            if ({q, done, busy, tc} !== e) $display("FAIL auto_reload cyc%0d: got q=%0d done=%b busy=%b tc=%b, expected q=%0d done=%b busy=%b tc=%b", i, q, done, busy, tc, e.q, e.done, e.busy, e.tc);
            else passed++;
        end
        checks++;
        if (pulses !== 4) $display("FAIL auto_reload_pulses: got %0d, expected 4", pulses);
        else passed++;
    endtask

    task automatic test_enable_gating();
        exp_t     e;
        int       qs[6] = '{4, 3, 3, 3, 2, 1};
        bit       ens[6] = '{0, 1, 0, 0, 1, 1};
        for (int i = 0; i < 6; i++) begin
            load        = (i == 0);
            load_val    = 4'd4;
            en          = ens[i];
            auto_reload = 1'b0;
            exp_q.push_back(mk(qs[i], 0, 1));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({q, done, busy, tc} !== e) $display("FAIL enable_gating cyc%0d: got q=%0d done=%b busy=%b tc=%b, expected q=%0d done=%b busy=%b tc=%b", i, q, done, busy, tc, e.q, e.done, e.busy, e.tc);
            else passed++;
        end
    endtask

    // Entered with q == 1 from the enable test, so the load collides with an expiry.
    task automatic test_collision_and_zero();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            load        = (i < 2);
            load_val    = (i == 0) ? 4'd9 : 4'd0;
            en          = 1'b1;
            auto_reload = 1'b1;
            exp_q.push_back(mk((i == 0) ? 9 : 0, 0, i == 0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({q, done, busy, tc} !== e) $display("FAIL collision_zero cyc%0d: got q=%0d done=%b busy=%b tc=%b, expected q=%0d done=%b busy=%b tc=%b", i, q, done, busy, tc, e.q, e.done, e.busy, e.tc);
            else passed++;
        end
    endtask

    task automatic test_max();
        exp_t e;
        int   pulses = 0;
        for (int i = 0; i < 18; i++) begin
            load        = (i == 0);
            load_val    = 4'd15;
            en          = 1'b1;
            auto_reload = 1'b0;
            exp_q.push_back(mk((i < 16) ? 15 - i : 0, i == 15, i < 15));
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
            e = exp_q.pop_front();
            checks++;
            if ({q, done, busy, tc} !== e) $display("FAIL max_load cyc%0d: got q=%0d done=%b busy=%b tc=%b, expected q=%0d done=%b busy=%b tc=%b", i, q, done, busy, tc, e.q, e.done, e.busy, e.tc);
            else passed++;
        end
        checks++;
        if (pulses !== 1) $display("FAIL max_load_pulses: got %0d, expected 1", pulses);
        else passed++;
    endtask

    task automatic test_async_reset();
        exp_t e;
        load = 1'b1; load_val = 4'd7; en = 1'b0; auto_reload = 1'b0;
        exp_q.push_back(mk(7, 0, 1));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if ({q, done, busy, tc} !== e) $display("FAIL async_reset_load: got q=%0d done=%b busy=%b tc=%b, expected q=%0d done=%b busy=%b tc=%b", q, done, busy, tc, e.q, e.done, e.busy, e.tc);
        else passed++;
        load = 1'b0; en = 1'b1;
        #2;
        rst = 1'b0;
        exp_q.push_back(mk(0, 0, 0));
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({q, done, busy, tc} !== e) $display("FAIL async_reset_immediate: got q=%0d done=%b busy=%b tc=%b, expected q=%0d done=%b busy=%b tc=%b", q, done, busy, tc, e.q, e.done, e.busy, e.tc);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(0, 0, 0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({q, done, busy, tc} !== e) $display("FAIL async_reset_after cyc%0d: got q=%0d done=%b busy=%b tc=%b, expected q=%0d done=%b busy=%b tc=%b", i, q, done, busy, tc, e.q, e.done, e.busy, e.tc);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_enable_gating();
        test_collision_and_zero();
        test_max();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sync_down_counter.md
SYNC_DOWN_COUNTER -- requirements
Module: sync_down_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 load  input  1  load request; samples load_val into count and reload registers.
REQ-005 load_val  input  WIDTH  start and reload value.
REQ-006 en  input  1  count enable; decrement permitted only when high.
REQ-007 auto_reload  input  1  at expiry, 1 = reload from reload register and keep counting, 0 = stop.
REQ-008 q  output  WIDTH  current count, registered.
REQ-009 tc  output  1  terminal count, combinational, high iff q == 0.
REQ-010 done  output  1  registered one-cycle pulse on expiry.
REQ-011 busy  output  1  registered, high iff FSM is in COUNT.

Function
REQ-012 FSM states: IDLE, COUNT; no other reachable state; illegal encodings SHALL return to IDLE on the next edge.
REQ-013 load has priority over en in every state; load with load_val != 0 -> q = load_val, reload register = load_val, state COUNT, next cycle.
REQ-014 load with load_val == 0 -> q = 0, reload register = 0, state IDLE, done not asserted.
REQ-015 IDLE: q holds, en ignored, done = 0.
REQ-016 COUNT, en = 0: q holds, state holds, done = 0.
REQ-017 COUNT, en = 1, q > 1: q = q - 1, single-cycle latency.
REQ-018 COUNT, en = 1, q == 1, auto_reload = 0: q = 0, state IDLE, done = 1 for exactly the following cycle.
REQ-019 COUNT, en = 1, q == 1, auto_reload = 1: q = reload register (1-step skip of 0), state stays COUNT, done = 1 for one cycle.
REQ-020 q SHALL never wrap below 0; no decrement occurs from q == 0 under any input combination.
REQ-021 load coincident with expiry: load wins, done not asserted that cycle.
REQ-022 Expiry period with auto_reload = 1 and en held high SHALL be exactly N cycles for reload value N.
REQ-023 auto_reload sampled only at the expiry edge; changing it mid-count has no other effect.

Reset
REQ-024 rst low asynchronously forces q = 0, reload register = 0, state IDLE, done = 0, busy = 0, independent of clk.
REQ-025 rst deasserted: first state change on the first rising clk edge after release; tc = 1 throughout reset.
REQ-026 Reset mid-count discards count and reload value; no done pulse is generated.

Structure
REQ-027 State encodings (IDLE = 1'b0, COUNT = 1'b1) and default WIDTH SHALL live in the shared counter definitions include file, not in the module.
REQ-028 Count, reload and done storage SHALL be built from one sub-module, d_flip_flop_en (single-bit D flip-flop, async active-low reset, enable), instantiated per bit.
REQ-029 Next-count logic (decrement, reload select, load select) SHALL be in the parent module, synchronous design only, no gated clocks.

Verification
REQ-030 Reset: rst low mid-count at q = 4'd7 -> q = 0, busy = 0, done = 0, tc = 1 immediately, without waiting for clk.
REQ-031 One-shot: load_val = 4'd5, auto_reload = 0, en high -> q sequence 5,4,3,2,1,0; done high one cycle as q reaches 0; busy falls same edge; q stays 0 for 10 more cycles.
REQ-032 Auto-reload: load_val = 4'd3, auto_reload = 1, en high for 12 cycles -> q 3,2,1,3,2,1,...; done every 3rd cycle, exactly 4 pulses.
REQ-033 Enable gating: load_val = 4'd4, en toggled 1,0,0,1,1 -> q 4,3,3,3,2,1; no done.
REQ-034 Collision: q = 1, en = 1, load = 1, load_val = 4'd9 -> q = 9, busy = 1, done = 0.
REQ-035 Zero/max: load_val = 0 -> IDLE, tc = 1, no done; load_val = 4'd15 with WIDTH = 4 -> 15 decrements to 0, single done.
